vga_timing_counter: RTL and testbench

- Free-running horizontal/vertical scan counter for the 640x480@60 VGA pipeline.
- Divides the system clock into a pixel-rate enable and produces hCount/vCount.
- vCount feeds the vertical sync generator; hCount feeds the horizontal sync generator.
- Also emits the active-video flag and line/frame boundary pulses consumed by the Game-of-Life pixel renderer.

---
 rtl/vga_timing_pkg.sv | 26 ++
 rtl/vga_timing_counter_pixel_tick.sv | 58 +++++
 rtl/vga_timing_counter.sv | 90 +++++++++
 tb/tb_vga_timing_counter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 VGA timing constants. The scan counter and the
// downstream sync generators all derive their geometry from this package.
package vga_timing_pkg;

  // Horizontal geometry, in pixels
  localparam int H_ACTIVE      = 640;
  localparam int H_FRONT_PORCH = 16;
  localparam int H_SYNC_PULSE  = 96;
  localparam int H_TOTAL       = 800;
  localparam int H_BACK_PORCH  = H_TOTAL - H_ACTIVE - H_FRONT_PORCH - H_SYNC_PULSE;

  // Vertical geometry, in lines
  localparam int V_ACTIVE      = 480;
  localparam int V_FRONT_PORCH = 10;
  localparam int V_SYNC_PULSE  = 2;
  localparam int V_TOTAL       = 525;
  localparam int V_BACK_PORCH  = V_TOTAL - V_ACTIVE - V_FRONT_PORCH - V_SYNC_PULSE;

  // System clocks per pixel: 50 MHz / 2 = 25 MHz pixel rate
  localparam int PIX_CLK_DIV   = 2;

  // Counter widths sized to hold 0..TOTAL-1
  localparam int HCNT_W        = $clog2(H_TOTAL);
  localparam int VCNT_W        = $clog2(V_TOTAL);

endpackage : vga_timing_pkg

// File: rtl/vga_timing_counter_pixel_tick.sv
// Pixel-rate enable generator: divides clk by CLK_DIV and gates the
// resulting one-clock tick with the run enable. The divider phase is
// held while en_i is low so a resumed scan produces no extra tick.
module vga_pixel_tick
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV = PIX_CLK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  output logic pix_tick_o
);

  generate
    if (CLK_DIV == 1) begin : g_no_div
      // Every enabled clock is a pixel step
      assign pix_tick_o = en_i;
    end else begin : g_div
      localparam int DIV_W = $clog2(CLK_DIV);
      localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

      logic [DIV_W-1:0] div_cnt_q;
      logic [DIV_W-1:0] div_cnt_d;
      logic             tick_s;

      // Tick on the last divider phase; next phase wraps by explicit compare
      always_comb begin
        tick_s    = 1'b0;
        div_cnt_d = div_cnt_q;
        if (en_i) begin
          if (div_cnt_q == DIV_LAST) begin
            tick_s    = 1'b1;
            div_cnt_d = '0;
          end else begin
            tick_s    = 1'b0;
            div_cnt_d = div_cnt_q + DIV_W'(1);
          end
        end else begin
          tick_s    = 1'b0;
          div_cnt_d = div_cnt_q;
        end
      end

      // Divider phase register
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          div_cnt_q <= '0;
        end else begin
          div_cnt_q <= div_cnt_d;
        end
      end

      assign pix_tick_o = tick_s;
    end
  endgenerate

endmodule : vga_pixel_tick

// File: rtl/vga_timing_counter.sv
// Free-running horizontal/vertical scan counter for the VGA pipeline.
// Steps hCount once per pixel tick, steps vCount at each line wrap, and
// flags active video plus line/frame boundary pulses for the renderer.
module vga_timing_counter #(
  parameter int H_TOTAL  = vga_timing_pkg::H_TOTAL,
  parameter int V_TOTAL  = vga_timing_pkg::V_TOTAL,
  parameter int H_ACTIVE = vga_timing_pkg::H_ACTIVE,
  parameter int V_ACTIVE = vga_timing_pkg::V_ACTIVE,
  parameter int CLK_DIV  = vga_timing_pkg::PIX_CLK_DIV
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  output logic                       pixTick,
  output logic [$clog2(H_TOTAL)-1:0] hCount,
  output logic [$clog2(V_TOTAL)-1:0] vCount,
  output logic                       videoOn,
  output logic                       lineEnd,
  output logic                       frameEnd
);

  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS  = HW'(H_ACTIVE);
  localparam logic [VW-1:0] V_VIS  = VW'(V_ACTIVE);

  logic          pix_tick_s;
  logic          h_last_s;
  logic          v_last_s;
  logic [HW-1:0] hcount_q;
  logic [HW-1:0] hcount_d;
  logic [VW-1:0] vcount_q;
  logic [VW-1:0] vcount_d;

  vga_pixel_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_pixel_tick (
    .clk        (clk),
    .rst_n      (rst_n),
    .en_i       (en),
    .pix_tick_o (pix_tick_s)
  );

  assign h_last_s = (hcount_q == H_LAST);
  assign v_last_s = (vcount_q == V_LAST);

  // Next scan position: wraps are explicit compares so counts never reach TOTAL
  always_comb begin
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    if (pix_tick_s) begin
      if (h_last_s) begin
        hcount_d = '0;
        if (v_last_s) begin
          vcount_d = '0;
        end else begin
          vcount_d = vcount_q + VW'(1);
        end
      end else begin
        hcount_d = hcount_q + HW'(1);
        vcount_d = vcount_q;
      end
    end else begin
      hcount_d = hcount_q;
      vcount_d = vcount_q;
    end
  end

  // Scan position registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcount_q <= '0;
      vcount_q <= '0;
    end else begin
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
    end
  end

  // Boundary pulses share the pixel tick so they are exactly one clock wide
  assign pixTick  = pix_tick_s;
  assign lineEnd  = pix_tick_s & h_last_s;
  assign frameEnd = pix_tick_s & h_last_s & v_last_s;
  assign hCount   = hcount_q;
  assign vCount   = vcount_q;
  assign videoOn  = (hcount_q < H_VIS) & (vcount_q < V_VIS);

endmodule : vga_timing_counter

// File: tb/tb_vga_timing_counter.sv
// Directed bench for vga_timing_counter: default 640x480 instance plus
// two shrunken-geometry instances for whole-frame period checks.
module tb_vga_timing_counter;

  logic clk;
  logic rst_n;
  logic en;
  logic en_s;

  // Default instance (CLK_DIV=2, 800x525)
  logic       pixTick, videoOn, lineEnd, frameEnd;
  logic [9:0] hCount;
  logic [9:0] vCount;

  // Small instance, CLK_DIV=2, 8x4 total, 5x3 active
  logic       s2_pixTick, s2_videoOn, s2_lineEnd, s2_frameEnd;
  logic [2:0] s2_hCount;
  logic [1:0] s2_vCount;

  // Small instance, CLK_DIV=1, 10x5 total, 6x3 active
  logic       s1_pixTick, s1_videoOn, s1_lineEnd, s1_frameEnd;
  logic [3:0] s1_hCount;
  logic [2:0] s1_vCount;

  int checks;
  int errors;

  vga_timing_counter dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .pixTick(pixTick), .hCount(hCount), .vCount(vCount),
    .videoOn(videoOn), .lineEnd(lineEnd), .frameEnd(frameEnd)
  );

  vga_timing_counter #(
    .H_TOTAL(8), .V_TOTAL(4), .H_ACTIVE(5), .V_ACTIVE(3), .CLK_DIV(2)
  ) dut_s2 (
    .clk(clk), .rst_n(rst_n), .en(en_s),
    .pixTick(s2_pixTick), .hCount(s2_hCount), .vCount(s2_vCount),
    .videoOn(s2_videoOn), .lineEnd(s2_lineEnd), .frameEnd(s2_frameEnd)
  );

  vga_timing_counter #(
    .H_TOTAL(10), .V_TOTAL(5), .H_ACTIVE(6), .V_ACTIVE(3), .CLK_DIV(1)
  ) dut_s1 (
    .clk(clk), .rst_n(rst_n), .en(en_s),
    .pixTick(s1_pixTick), .hCount(s1_hCount), .vCount(s1_vCount),
    .videoOn(s1_videoOn), .lineEnd(s1_lineEnd), .frameEnd(s1_frameEnd)
  );

  // 100 MHz-style clock, posedges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int saw_tick;
    int fe2_n, fe2_a, fe2_b, fe1_n, fe1_a, fe1_b;
    int fe2_h, fe2_v, fe1_h, fe1_v;
    int maxv2, maxv1, s1_low;
    int post2_h, post2_v, post1_h, post1_v;

    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    en     = 1'b0;
    en_s   = 1'b0;

    // Reset state
    #12;
    chk("rst_hCount",   32'(hCount),   32'd0);
    chk("rst_vCount",   32'(vCount),   32'd0);
    chk("rst_pixTick",  32'(pixTick),  32'd0);
    chk("rst_lineEnd",  32'(lineEnd),  32'd0);
    chk("rst_frameEnd", 32'(frameEnd), 32'd0);
    chk("rst_videoOn",  32'(videoOn),  32'd1);

    // Release and run; divider starts at phase 0
    tick(1);
    rst_n = 1'b1;
    en    = 1'b1;
    #1;
    chk("first_no_tick", 32'(pixTick), 32'd0);
    tick(1);
    chk("tick_clk1",     32'(pixTick), 32'd1);
    chk("h_before_step", 32'(hCount),  32'd0);
    tick(1);
    chk("h_after_2clk",  32'(hCount),  32'd1);
    chk("tick_clk2_low", 32'(pixTick), 32'd0);

    // Active/blank horizontal boundary
    tick(2 * 638);
    chk("h639",         32'(hCount),  32'd639);
    chk("h639_videoOn", 32'(videoOn), 32'd1);
    tick(2);
    chk("h640",         32'(hCount),  32'd640);
    chk("h640_videoOn", 32'(videoOn), 32'd0);

    // Line end
    tick(2 * 159);
    chk("h799",             32'(hCount),  32'd799);
    chk("h799_no_lineEnd",  32'(lineEnd), 32'd0);
    tick(1);
    chk("lineEnd_pulse",    32'(lineEnd),  32'd1);
    chk("lineEnd_noframe",  32'(frameEnd), 32'd0);
    tick(1);
    chk("line_wrap_h",      32'(hCount),  32'd0);
    chk("line_wrap_v",      32'(vCount),  32'd1);
    chk("lineEnd_1clk",     32'(lineEnd), 32'd0);

    // Freeze at hCount=100 for 50 clocks (divider at phase 0)
    tick(200);
    chk("h100", 32'(hCount), 32'd100);
    en = 1'b0;
    saw_tick = 0;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      if (pixTick || lineEnd) saw_tick++;
    end
    chk("freeze_no_tick", 32'(saw_tick), 32'd0);
    chk("freeze_h",       32'(hCount),   32'd100);
    en = 1'b1;
    tick(1);
    chk("resume_h_held",  32'(hCount),   32'd100);
    tick(1);
    chk("resume_h101",    32'(hCount),   32'd101);

    // Freeze again with the divider at its last phase
    tick(1);
    chk("phase1_tick",     32'(pixTick), 32'd1);
    en = 1'b0;
    #1;
    chk("en_low_gates",    32'(pixTick), 32'd0);
    tick(3);
    chk("freeze2_h",       32'(hCount),  32'd101);
    en = 1'b1;
    #1;
    chk("phase_held_tick", 32'(pixTick), 32'd1);
    tick(1);
    chk("resume2_h102",    32'(hCount),  32'd102);

    // Asynchronous reset mid-line
    tick(2 * 198);
    chk("h300", 32'(hCount), 32'd300);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_h",      32'(hCount),  32'd0);
    chk("async_v",      32'(vCount),  32'd0);
    chk("async_tick",   32'(pixTick), 32'd0);
    #1;
    rst_n = 1'b1;
    tick(1);
    chk("post_rst_tick1", 32'(pixTick), 32'd1);
    chk("post_rst_h0",    32'(hCount),  32'd0);
    tick(1);
    chk("post_rst_h1",    32'(hCount),  32'd1);

    // Full-frame periods on the small instances
    en = 1'b0;
    #1;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    en_s  = 1'b1;
    fe2_n = 0; fe2_a = 0; fe2_b = 0; fe1_n = 0; fe1_a = 0; fe1_b = 0;
    fe2_h = 0; fe2_v = 0; fe1_h = 0; fe1_v = 0;
    maxv2 = 0; maxv1 = 0; s1_low = 0;
    post2_h = 99; post2_v = 99; post1_h = 99; post1_v = 99;
    for (int e = 1; e <= 130; e++) begin
      tick(1);
      if (int'(s2_vCount) > maxv2) maxv2 = int'(s2_vCount);
      if (int'(s1_vCount) > maxv1) maxv1 = int'(s1_vCount);
      if (!s1_pixTick) s1_low++;
      if (s2_frameEnd) begin
        fe2_n++;
        if (fe2_n == 1) begin
          fe2_a = e; fe2_h = int'(s2_hCount); fe2_v = int'(s2_vCount);
        end else if (fe2_n == 2) begin
          fe2_b = e;
        end
      end
      if (s1_frameEnd) begin
        fe1_n++;
        if (fe1_n == 1) begin
          fe1_a = e; fe1_h = int'(s1_hCount); fe1_v = int'(s1_vCount);
        end else if (fe1_n == 2) begin
          fe1_b = e;
        end
      end
      if (e == 64) begin post2_h = int'(s2_hCount); post2_v = int'(s2_vCount); end
      if (e == 50) begin post1_h = int'(s1_hCount); post1_v = int'(s1_vCount); end
    end
    chk("s2_frame_count",  32'(fe2_n),       32'd2);
    chk("s2_frame_first",  32'(fe2_a),       32'd63);
    chk("s2_frame_period", 32'(fe2_b - fe2_a), 32'd64);
    chk("s2_frame_h",      32'(fe2_h),       32'd7);
    chk("s2_frame_v",      32'(fe2_v),       32'd3);
    chk("s2_wrap_h",       32'(post2_h),     32'd0);
    chk("s2_wrap_v",       32'(post2_v),     32'd0);
    chk("s2_max_v",        32'(maxv2),       32'd3);
    chk("s1_frame_count",  32'(fe1_n),       32'd2);
    chk("s1_frame_first",  32'(fe1_a),       32'd49);
    chk("s1_frame_period", 32'(fe1_b - fe1_a), 32'd50);
    chk("s1_frame_h",      32'(fe1_h),       32'd9);
    chk("s1_frame_v",      32'(fe1_v),       32'd4);
    chk("s1_wrap_h",       32'(post1_h),     32'd0);
    chk("s1_wrap_v",       32'(post1_v),     32'd0);
    chk("s1_max_v",        32'(maxv1),       32'd4);
    chk("s1_tick_always",  32'(s1_low),      32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_vga_timing_counter
